// File: rtl/gcn_coo_aggregation.sv
// GCN aggregation stage.
// Latches the transformed feature matrix, then walks the COO edge list one
// edge per cycle. For each valid undirected edge (a,b) the neighbour's latched
// row is added into each endpoint's running sum. Each row starts from its own
// self term. done rises once the last edge has been consumed.
module gcn_coo_aggregation #(
  parameter int FEATURE_ROWS    = 6,
  parameter int WEIGHT_COLS     = 3,
  parameter int DOT_PROD_WIDTH  = 16,
  parameter int NUM_OF_NODES    = 6,
  parameter int COO_NUM_OF_COLS = 6,
  parameter int COO_NUM_OF_ROWS = 2,
  parameter int COO_BW          = $clog2(COO_NUM_OF_COLS)
) (
  input  logic                                                          clk,
  input  logic                                                          reset,
  input  logic                                                          start,
  input  logic [0:FEATURE_ROWS-1][0:WEIGHT_COLS-1][DOT_PROD_WIDTH-1:0] fm_in,
  input  logic [0:COO_NUM_OF_ROWS-1][COO_BW-1:0]                        coo_in,
  output logic [COO_BW-1:0]                                             coo_address,
  output logic [0:FEATURE_ROWS-1][0:WEIGHT_COLS-1][DOT_PROD_WIDTH-1:0] agg_out,
  output logic                                                          done
);

  typedef enum logic [1:0] {IDLE, EDGE, DONE} state_t;

  typedef logic [0:WEIGHT_COLS-1][DOT_PROD_WIDTH-1:0] row_t;
  typedef logic [0:FEATURE_ROWS-1][0:WEIGHT_COLS-1][DOT_PROD_WIDTH-1:0] matrix_t;

  localparam logic [COO_BW-1:0] LAST_EDGE = COO_BW'(COO_NUM_OF_COLS - 1);

  state_t          state;
  state_t          next_state;
  matrix_t         fm_reg;
  matrix_t         agg_next;
  logic [COO_BW-1:0] node_a;
  logic [COO_BW-1:0] node_b;
  logic            edge_valid;
  row_t            row_a;
  row_t            row_b;

  assign node_a = coo_in[0];
  assign node_b = coo_in[1];
  assign edge_valid = (node_a != '0) && (int'(node_a) <= NUM_OF_NODES) &&
                      (node_b != '0) && (int'(node_b) <= NUM_OF_NODES);

  // Pick the latched rows of both endpoints (1-based IDs) without out-of-range indexing.
  always_comb begin
    row_a = '0;
    row_b = '0;
    for (int r = 0; r < FEATURE_ROWS; r++) begin
      if (int'(node_a) == r + 1) row_a = fm_reg[r];
      if (int'(node_b) == r + 1) row_b = fm_reg[r];
    end
  end

  // Sums after consuming the current edge; a self-edge adds its own row once.
  always_comb begin
    agg_next = agg_out;
    if (edge_valid) begin
      for (int r = 0; r < FEATURE_ROWS; r++) begin
        for (int c = 0; c < WEIGHT_COLS; c++) begin
          if (int'(node_a) == r + 1)
            agg_next[r][c] = agg_out[r][c] + row_b[c];
          else if (int'(node_b) == r + 1)
            agg_next[r][c] = agg_out[r][c] + row_a[c];
        end
      end
    end
  end

  // Next-state selection: start launches a run, last edge finishes it, start low rearms.
  always_comb begin
    next_state = state;
    case (state)
      IDLE:    if (start) next_state = EDGE;
      EDGE:    if (coo_address == LAST_EDGE) next_state = DONE;
      DONE:    if (!start) next_state = IDLE;
      default: next_state = IDLE;
    endcase
  end

  // State register.
  always_ff @(posedge clk) begin
    if (reset) state <= IDLE;
    else       state <= next_state;
  end

  // Datapath: latch FM, accumulate per edge, advance the edge address, drive done.
  always_ff @(posedge clk) begin
    if (reset) begin
      fm_reg      <= '0;
      agg_out     <= '0;
      coo_address <= '0;
      done        <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          done <= 1'b0;
          if (start) begin
            fm_reg      <= fm_in;
            agg_out     <= fm_in;
            coo_address <= '0;
          end
        end
        EDGE: begin
          agg_out <= agg_next;
          if (coo_address == LAST_EDGE) done <= 1'b1;
          else coo_address <= coo_address + 1'b1;
        end
        DONE: begin
          if (!start) done <= 1'b0;
        end
        default: done <= 1'b0;
      endcase
    end
  end

endmodule

// File: tb/tb_gcn_coo_aggregation.sv
// Directed testbench for gcn_coo_aggregation with hand-computed expected matrices.
module tb_gcn_coo_aggregation;

  localparam int ROWS = 6;
  localparam int COLS = 3;
  localparam int DW   = 16;
  localparam int BW   = 3;
  localparam int MW   = ROWS * COLS * DW;

  logic clk;
  logic reset;
  logic start;
  logic [0:ROWS-1][0:COLS-1][DW-1:0] fm_in;
  logic [0:1][BW-1:0]                coo_in;
  logic [BW-1:0]                     coo_address;
  logic [0:ROWS-1][0:COLS-1][DW-1:0] agg_out;
  logic                              done;

  logic [0:ROWS-1][0:COLS-1][DW-1:0] exp_agg;
  logic [0:1][BW-1:0]                coo_mem [0:7];

  int checks;
  int failures;

  gcn_coo_aggregation dut (
    .clk(clk),
    .reset(reset),
    .start(start),
    .fm_in(fm_in),
    .coo_in(coo_in),
    .coo_address(coo_address),
    .agg_out(agg_out),
    .done(done)
  );

  // Free-running clock, rising edges at 5, 15, 25, ...
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Edge-list memory read combinationally at the current address.
  assign coo_in = coo_mem[coo_address];

  task automatic checkOutput(input string tag, input logic [MW-1:0] observed,
                             input logic [MW-1:0] expected);
    checks++;
    if (observed !== expected) begin
      failures++;
      $display("[TB] FAIL %s observed=%h expected=%h", tag, observed, expected);
    end
  endtask

  task automatic clearEdges();
    for (int i = 0; i < 8; i++) coo_mem[i] = '0;
  endtask

  task automatic setEdge(input int idx, input int a, input int b);
    coo_mem[idx][0] = BW'(a);
    coo_mem[idx][1] = BW'(b);
  endtask

  task automatic setRow(input int r, input logic [DW-1:0] v);
    for (int c = 0; c < COLS; c++) fm_in[r][c] = v;
  endtask

  task automatic setExpRow(input int r, input logic [DW-1:0] v);
    for (int c = 0; c < COLS; c++) exp_agg[r][c] = v;
  endtask

  task automatic loadRing();
    clearEdges();
    setEdge(0, 1, 2); setEdge(1, 2, 3); setEdge(2, 3, 4);
    setEdge(3, 4, 5); setEdge(4, 5, 6); setEdge(5, 6, 1);
    for (int r = 0; r < ROWS; r++) setRow(r, DW'(r + 1));
    setExpRow(0, 9);  setExpRow(1, 6);  setExpRow(2, 9);
    setExpRow(3, 12); setExpRow(4, 15); setExpRow(5, 12);
  endtask

  // Raise start, follow the fixed six-edge walk, check the result, then release start.
  // When scramble is set, fm_in is overwritten after it was sampled.
  task automatic applyStimulus(input string name, input bit scramble);
    start = 1'b1;
    for (int k = 0; k < 6; k++) begin
      @(negedge clk);
      if (scramble && k == 0) fm_in = {MW{1'b1}};
      checkOutput({name, "_addr"}, MW'(coo_address), MW'(k));
      checkOutput({name, "_done_low"}, MW'(done), MW'(0));
    end
    @(negedge clk);
    checkOutput({name, "_done_high"}, MW'(done), MW'(1));
    checkOutput({name, "_addr_hold"}, MW'(coo_address), MW'(5));
    checkOutput({name, "_agg"}, agg_out, exp_agg);
    @(negedge clk);
    checkOutput({name, "_no_retrigger"}, MW'(done), MW'(1));
    checkOutput({name, "_agg_stable"}, agg_out, exp_agg);
    start = 1'b0;
    @(negedge clk);
    checkOutput({name, "_done_drop"}, MW'(done), MW'(0));
    @(negedge clk);
  endtask

  initial begin
    checks   = 0;
    failures = 0;
    reset    = 1'b1;
    start    = 1'b1;
    fm_in    = '0;
    exp_agg  = '0;
    clearEdges();
    for (int r = 0; r < ROWS; r++) setRow(r, 16'h1234);
    repeat (2) @(negedge clk);
    checkOutput("reset_done", MW'(done), MW'(0));
    checkOutput("reset_addr", MW'(coo_address), MW'(0));
    checkOutput("reset_agg", agg_out, '0);
    start = 1'b0;
    reset = 1'b0;
    @(negedge clk);

    // Ring graph
    loadRing();
    applyStimulus("ring", 1'b0);

    // Invalid IDs skipped; FM changed after sampling must not matter
    clearEdges();
    setEdge(0, 0, 3); setEdge(1, 7, 1); setEdge(2, 1, 2);
    for (int r = 0; r < ROWS; r++) begin setRow(r, 10); setExpRow(r, 10); end
    setExpRow(0, 20); setExpRow(1, 20);
    applyStimulus("invalid", 1'b1);

    // Self-edge adds its own row exactly once
    clearEdges();
    setEdge(0, 2, 2);
    for (int r = 0; r < ROWS; r++) begin setRow(r, DW'(r + 1)); setExpRow(r, DW'(r + 1)); end
    setRow(1, 5);
    setExpRow(1, 10);
    applyStimulus("self", 1'b0);

    // Modulo wrap in column 0
    clearEdges();
    setEdge(0, 1, 2);
    fm_in   = '0;
    exp_agg = '0;
    fm_in[0][0] = 16'hFFFF;
    fm_in[1][0] = 16'h0002;
    fm_in[0][2] = 16'h0003;
    exp_agg[0][0] = 16'h0001;
    exp_agg[1][0] = 16'h0001;
    exp_agg[0][2] = 16'h0003;
    exp_agg[1][2] = 16'h0003;
    applyStimulus("overflow", 1'b0);

    // Reset in the middle of the edge walk
    loadRing();
    start = 1'b1;
    repeat (4) @(negedge clk);
    checkOutput("midreset_addr_before", MW'(coo_address), MW'(3));
    reset = 1'b1;
    start = 1'b0;
    @(negedge clk);
    checkOutput("midreset_done", MW'(done), MW'(0));
    checkOutput("midreset_agg", agg_out, '0);
    checkOutput("midreset_addr", MW'(coo_address), MW'(0));
    reset = 1'b0;
    @(negedge clk);
    applyStimulus("ring_after_reset", 1'b0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
